// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default widths for the 2R1W register file.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one-hot AND-OR read mux over the register array.
// With REGFILE_BYPASS_EN defined, an accepted write to the addressed
// register is forwarded combinationally to the output.
module regfile_read_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] readnum,
`ifdef REGFILE_BYPASS_EN
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
`endif
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [NREGS-1:0]  sel;
  logic [DATA_W-1:0] stored;

  // Decode the read index and AND-OR the selected register onto the bus.
  always_comb begin
    sel          = '0;
    sel[readnum] = 1'b1;
    stored       = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      stored = stored | (regs[i] & {DATA_W{sel[i]}});
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write data when it targets this port's register.
  always_comb begin
    data_out = stored;
    if (byp_en && (byp_addr == readnum)) data_out = byp_data;
  end
`else
  // Stored contents only; new values appear after the committing edge.
  always_comb begin
    data_out = stored;
  end
`endif

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with a sequential clear sweep
// that zeroes one register per cycle while busy is high.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              clear_req,
  output logic              busy
);

  localparam int unsigned NREGS = 2**ADDR_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NREGS];
  logic              last_idx;

  assign busy     = (state == CLEAR);
  assign last_idx = (idx == '1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: start a sweep from IDLE on request, leave after the last register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_req) state_next = CLEAR;
      CLEAR:   if (last_idx)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register array and sweep index: writes only in IDLE, one clear per CLEAR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[idx] <= '0;
      idx       <= idx + 1'b1;
    end else begin
      if (write)     regs[writenum] <= data_in;
      if (clear_req) idx <= '0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  assign byp_en = write && (state == IDLE);

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .regs(regs), .readnum(readnum_a),
    .byp_en(byp_en), .byp_addr(writenum), .byp_data(data_in),
    .data_out(data_out_a)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .regs(regs), .readnum(readnum_b),
    .byp_en(byp_en), .byp_addr(writenum), .byp_data(data_in),
    .data_out(data_out_b)
  );
`else
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .regs(regs), .readnum(readnum_a), .data_out(data_out_a)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .regs(regs), .readnum(readnum_b), .data_out(data_out_b)
  );
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed checks of reads, writes, bypass, clear sweep and reset.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic [15:0] data_out_a;
  logic [15:0] data_out_b;
  logic        clear_req;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cnt;

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum),
    .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b),
    .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read register n on both ports and compare against exp.
  task automatic chk_reg(input string tag, input logic [2:0] n, input logic [15:0] exp);
    readnum_a = n;
    readnum_b = n;
    #1;
    chk({tag, "_a"}, data_out_a, exp);
    chk({tag, "_b"}, data_out_b, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] n, input logic [15:0] d);
    writenum = n;
    data_in  = d;
    write    = 1'b1;
    tick();
    write    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data_in = '0; writenum = '0; write = 1'b0;
    readnum_a = '0; readnum_b = '0; clear_req = 1'b0;
    #12;
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk_reg("reset_r0", 3'd0, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Dual read in the same cycle.
    wr(3'd2, 16'hBEEF);
    wr(3'd5, 16'h1234);
    readnum_a = 3'd2; readnum_b = 3'd5;
    #1;
    chk("dual_a", data_out_a, 16'hBEEF);
    chk("dual_b", data_out_b, 16'h1234);

    // Mid-run reset clears everything.
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    for (int i = 0; i < 8; i++) chk_reg("rst_read", 3'(i), 16'h0000);
    rst_n = 1'b1;
    tick();

    // Bypass: write R3 while reading R3 on port A.
    readnum_a = 3'd3;
    writenum = 3'd3; data_in = 16'hA5A5; write = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_before", data_out_a, 16'hA5A5);
`else
    chk("byp_before", data_out_a, 16'h0000);
`endif
    tick();
    write = 1'b0;
    #1;
    chk("byp_after", data_out_a, 16'hA5A5);

    // Clear sweep.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h0011 * 16'(i + 1));
    chk_reg("fill_r7", 3'd7, 16'h0088);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("sweep_busy_rise", {15'd0, busy}, 16'd1);
    cnt = 0;
    while (busy && cnt < 20) begin
      tick();
      cnt++;
      if (cnt == 3) begin
        chk_reg("sweep3_r0", 3'd0, 16'h0000);
        chk_reg("sweep3_r2", 3'd2, 16'h0000);
        chk_reg("sweep3_r3", 3'd3, 16'h0044);
      end
    end
    chk("sweep_len", 16'(cnt), 16'd8);
    for (int i = 0; i < 8; i++) chk_reg("sweep_done", 3'(i), 16'h0000);

    // Writes and a second clear_req during busy are dropped.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h0101 * 16'(i + 1));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      if (cnt == 1) begin writenum = 3'd6; data_in = 16'hFFFF; write = 1'b1; end
      if (cnt == 2) begin write = 1'b0; clear_req = 1'b1; end
      if (cnt == 3) clear_req = 1'b0;
      if (cnt == 4) begin writenum = 3'd0; data_in = 16'h5555; write = 1'b1; end
      if (cnt == 5) write = 1'b0;
      tick();
      cnt++;
    end
    write = 1'b0; clear_req = 1'b0;
    chk("busy_len2", 16'(cnt), 16'd8);
    chk_reg("drop_r6", 3'd6, 16'h0000);
    chk_reg("drop_r0", 3'd0, 16'h0000);
    tick();
    chk("no_requeue", {15'd0, busy}, 16'd0);

    // Reset in the 4th busy cycle.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1111 * 16'(i + 1));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("midsweep_busy", {15'd0, busy}, 16'd0);
    for (int i = 0; i < 8; i++) chk_reg("midsweep_read", 3'(i), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(3'd4, 16'h4242);
    chk_reg("post_rst_wr", 3'd4, 16'h4242);
    chk("post_rst_busy", {15'd0, busy}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
